// File: rtl/fpu_mul_vec_sf_pkg.sv
// fpu_mul_vec_sf_pkg: shared FP32 constants, rounding modes and operand classes
package fpu_mul_vec_sf_pkg;
  typedef enum logic [1:0] {RM_RNE = 2'd0, RM_RTZ = 2'd1, RM_RDN = 2'd2, RM_RUP = 2'd3} rMode_t;
  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fpClass_t;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int SIG_W = MAN_W + 1;
  localparam logic signed [9:0] BIAS = 10'sd127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] MAXF = 32'h7F7FFFFF;
  localparam logic [31:0] INF = 32'h7F800000;
  function automatic fpClass_t classify(input logic [31:0] x);
    return x[30:23] == 8'hFF ? (x[22:0] == '0 ? CLS_INF : x[22] ? CLS_QNAN : CLS_SNAN)
         : x[30:23] == 8'h00 ? CLS_ZERO : CLS_NORM;
  endfunction
endpackage

// File: rtl/fpu_mul_sf_lane.sv
// fpu_mul_sf_lane: one FP32 lane, 3 stages (unpack/exp, 24x24 product, normalise+round)
module fpu_mul_sf_lane
  import fpu_mul_vec_sf_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        en1,
  input  logic        en2,
  input  logic        en3,
  input  logic [1:0]  rMode,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  output logic [31:0] result,
  output logic [3:0]  flags
);
  fpClass_t clsA, clsB, cls, s1Cls, s2Cls;
  logic s1Sign, s2Sign;
  logic signed [9:0] s1Exp, s2Exp, expN, expR;
  logic [1:0] s1Rm, s2Rm;
  logic [SIG_W-1:0] s1SigA, s1SigB, sig;
  logic [2*SIG_W-1:0] s2Prod;
  logic [SIG_W:0] sum;
  logic hi, guard, sticky, inc, lost, toInf, under, over, isNorm;
  logic [31:0] res;
  logic unusedMsb;
  always_comb begin
    clsA = classify(opA);
    clsB = classify(opB);
    // Inf x 0 shares the signalling-NaN class: both give QNAN and raise invalid
    cls = (clsA == CLS_SNAN || clsB == CLS_SNAN || (clsA == CLS_INF && clsB == CLS_ZERO)
           || (clsA == CLS_ZERO && clsB == CLS_INF)) ? CLS_SNAN
        : (clsA == CLS_QNAN || clsB == CLS_QNAN) ? CLS_QNAN
        : (clsA == CLS_INF || clsB == CLS_INF) ? CLS_INF
        : (clsA == CLS_ZERO || clsB == CLS_ZERO) ? CLS_ZERO : CLS_NORM;
  end
  always_ff @(posedge clock)
    if (en1) begin
      s1Sign <= opA[31] ^ opB[31];
      s1Exp  <= 10'(opA[30:23]) + 10'(opB[30:23]) - BIAS;
      s1Cls  <= cls;
      s1Rm   <= rMode;
      s1SigA <= {1'b1, opA[22:0]};
      s1SigB <= {1'b1, opB[22:0]};
    end
  always_ff @(posedge clock)
    if (en2) begin
      s2Sign <= s1Sign;
      s2Exp  <= s1Exp;
      s2Cls  <= s1Cls;
      s2Rm   <= s1Rm;
      s2Prod <= s1SigA * s1SigB;
    end
  always_comb begin
    hi     = s2Prod[47];
    sig    = hi ? s2Prod[47:24] : s2Prod[46:23];
    guard  = hi ? s2Prod[23] : s2Prod[22];
    sticky = hi ? |s2Prod[22:0] : |s2Prod[21:0];
    expN   = s2Exp + 10'(hi);
    lost   = guard | sticky;
    inc    = s2Rm == RM_RNE ? guard & (sticky | sig[0])
           : s2Rm == RM_RDN ? s2Sign & lost
           : s2Rm == RM_RUP ? !s2Sign & lost : 1'b0;
    sum    = {1'b0, sig} + 25'(inc);
    expR   = expN + 10'(sum[24]);
    toInf  = s2Rm == RM_RNE || (s2Rm == RM_RDN && s2Sign) || (s2Rm == RM_RUP && !s2Sign);
    under  = expN <= 10'sd0;
    over   = expR >= 10'sd255;
    isNorm = s2Cls == CLS_NORM;
    res    = (s2Cls == CLS_SNAN || s2Cls == CLS_QNAN) ? QNAN
           : s2Cls == CLS_INF ? {s2Sign, INF[30:0]}
           : (s2Cls == CLS_ZERO || under) ? {s2Sign, 31'd0}
           : over ? {s2Sign, toInf ? INF[30:0] : MAXF[30:0]}
           : {s2Sign, expR[7:0], sum[22:0]};
    flags  = {s2Cls == CLS_SNAN, isNorm & !under & over, isNorm & under,
              isNorm & (under | over | lost)};
  end
  assign unusedMsb = sum[23];
  always_ff @(posedge clock or negedge reset)
    if (!reset) result <= '0;
    else if (en3) result <= res;
endmodule

// File: rtl/fpu_mul_vec_sf.sv
// fpu_mul_vec_sf: packed LANES x FP32 multiplier, 3-stage pipe with sticky flags.
// Sticky flag logic is present only when FPU_MULVEC_FLAGS_EN is defined.
module fpu_mul_vec_sf
  import fpu_mul_vec_sf_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DAZ   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exHold,
  input  logic                  inValid,
  input  logic [32*LANES-1:0]   regValRs,
  input  logic [32*LANES-1:0]   regValRt,
  input  logic [7:0]            regRMode,
  output logic [32*LANES-1:0]   regValRo,
  output logic                  outValid,
  input  logic                  flagClr,
  output logic [3:0]            fpFlags
);
  logic v1, v2;
  logic [4*LANES-1:0] laneFlags;
  logic [3:0] beatFlags;
  logic unusedRMode;
  if (DAZ != 1) begin : gDazReserved
    $error("fpu_mul_vec_sf: only DAZ=1 is supported");
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) {v1, v2, outValid} <= '0;
    else if (!exHold) {v1, v2, outValid} <= {inValid, v1, v2};
  for (genvar i = 0; i < LANES; i++) begin : gLane
    fpu_mul_sf_lane uLane (
      .clock  (clock),
      .reset  (reset),
      .en1    (!exHold && inValid),
      .en2    (!exHold && v1),
      .en3    (!exHold && v2),
      .rMode  (regRMode[1:0]),
      .opA    (regValRs[32*i+:32]),
      .opB    (regValRt[32*i+:32]),
      .result (regValRo[32*i+:32]),
      .flags  (laneFlags[4*i+:4])
    );
  end
  always_comb begin
    beatFlags = '0;
    for (int i = 0; i < LANES; i++) beatFlags = beatFlags | laneFlags[4*i+:4];
  end
  assign unusedRMode = ^regRMode[7:2];
`ifdef FPU_MULVEC_FLAGS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) fpFlags <= '0;
    else if (flagClr) fpFlags <= '0;
    else if (!exHold && v2) fpFlags <= fpFlags | beatFlags;
`else
  logic unusedFlags;
  assign fpFlags = '0;
  assign unusedFlags = ^{flagClr, beatFlags};
`endif
endmodule

// File: tb/tb_fpu_mul_vec_sf.sv
// tb_fpu_mul_vec_sf: scoreboard bench for the packed FP32 multiplier
module tb_fpu_mul_vec_sf;
`ifdef FPU_MULVEC_FLAGS_EN
  localparam bit FLAGS_EN = 1'b1;
`else
  localparam bit FLAGS_EN = 1'b0;
`endif
  localparam logic [7:0] RNE = 8'd0, RTZ = 8'd1, RDN = 8'd2, RUP = 8'd3;
  logic clock = 1'b0, reset = 1'b0, exHold = 1'b0, inValid = 1'b0, flagClr = 1'b0;
  logic [63:0] regValRs = '0, regValRt = '0, regValRo;
  logic [7:0] regRMode = '0;
  logic outValid;
  logic [3:0] fpFlags;
  int checks = 0, failures = 0;
  logic [63:0] sb[$];
  logic [63:0] expRes;
  logic advEdge = 1'b0;

  always #5 clock = ~clock;

  fpu_mul_vec_sf #(.LANES(2), .DAZ(1)) dut (
    .clock(clock), .reset(reset), .exHold(exHold), .inValid(inValid),
    .regValRs(regValRs), .regValRt(regValRt), .regRMode(regRMode),
    .regValRo(regValRo), .outValid(outValid), .flagClr(flagClr), .fpFlags(fpFlags)
  );

  always @(posedge clock) advEdge <= !exHold;

  // a new beat is visible after an edge that advanced the pipe
  always @(negedge clock)
    if (reset && outValid && advEdge) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat got=%h expected=none", regValRo);
      end else begin
        expRes = sb.pop_front();
        if (regValRo !== expRes) begin
          failures++;
          $display("FAIL beat_result got=%h expected=%h", regValRo, expRes);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [7:0] rm,
                       input logic [63:0] e);
    regValRs = a;
    regValRt = b;
    regRMode = rm;
    inValid = 1'b1;
    if (!exHold) sb.push_back(e);
    tick();
    inValid = 1'b0;
  endtask

  task automatic clear_flags;
    flagClr = 1'b1;
    tick();
    flagClr = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 20 && sb.size() != 0; n++) tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected=0", name, sb.size());
    end
  endtask

  task automatic test_reset;
    #1;
    checks += 3;
    if (outValid !== 1'b0) begin failures++; $display("FAIL reset_outValid got=%b expected=0", outValid); end
    if (regValRo !== 64'd0) begin failures++; $display("FAIL reset_result got=%h expected=0", regValRo); end
    if (fpFlags !== 4'd0) begin failures++; $display("FAIL reset_flags got=%b expected=0000", fpFlags); end
    #1 reset = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    clear_flags();
    issue({32'hC0400000, 32'h3FC00000}, {32'h3F000000, 32'h40000000}, 8'hA8 | RNE,
          {32'hBFC00000, 32'h40400000});
    tick();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b expected=0", outValid); end
    tick();
    checks += 2;
    if (outValid !== 1'b1) begin failures++; $display("FAIL basic_latency got=%b expected=1", outValid); end
    if (fpFlags !== 4'd0) begin failures++; $display("FAIL basic_flags got=%b expected=0000", fpFlags); end
    tick();
    checks++;
    if (outValid !== 1'b0) begin failures++; $display("FAIL basic_pulse got=%b expected=0", outValid); end
    drain("basic");
  endtask

  task automatic test_rounding;
    logic [3:0] ef;
    clear_flags();
    issue({32'h3F800000, 32'h3F800001}, {32'h3F800000, 32'h3F800001}, RNE, {32'h3F800000, 32'h3F800002});
    issue({32'h3F800000, 32'h3F800001}, {32'h3F800000, 32'h3F800001}, RTZ, {32'h3F800000, 32'h3F800002});
    issue({32'h3F800000, 32'h3F800001}, {32'h3F800000, 32'h3F800001}, RUP, {32'h3F800000, 32'h3F800003});
    issue({32'hBF800000, 32'hBF800001}, {32'h3F800000, 32'h3F800001}, RDN, {32'hBF800000, 32'hBF800003});
    drain("rounding");
    ef = FLAGS_EN ? 4'b0001 : 4'b0000;
    checks++;
    if (fpFlags !== ef) begin failures++; $display("FAIL rounding_flags got=%b expected=%b", fpFlags, ef); end
  endtask

  task automatic test_range;
    logic [3:0] ef;
    clear_flags();
    issue({32'hFF000000, 32'h7F000000}, {32'h7F000000, 32'h7F000000}, RNE, {32'hFF800000, 32'h7F800000});
    issue({32'hFF000000, 32'h7F000000}, {32'h7F000000, 32'h7F000000}, RTZ, {32'hFF7FFFFF, 32'h7F7FFFFF});
    issue({32'hFF000000, 32'h7F000000}, {32'h7F000000, 32'h7F000000}, RUP, {32'hFF7FFFFF, 32'h7F800000});
    drain("overflow");
    ef = FLAGS_EN ? 4'b0101 : 4'b0000;
    checks++;
    if (fpFlags !== ef) begin failures++; $display("FAIL overflow_flags got=%b expected=%b", fpFlags, ef); end
    clear_flags();
    issue({32'h80400000, 32'h00800000}, {32'h3F800000, 32'h3F000000}, RNE, {32'h80000000, 32'h00000000});
    drain("underflow");
    ef = FLAGS_EN ? 4'b0011 : 4'b0000;
    checks++;
    if (fpFlags !== ef) begin failures++; $display("FAIL underflow_flags got=%b expected=%b", fpFlags, ef); end
  endtask

  task automatic test_specials;
    logic [3:0] ef;
    clear_flags();
    issue({32'hFF800000, 32'h7F800000}, {32'h40000000, 32'h00000000}, RNE, {32'hFF800000, 32'h7FC00000});
    drain("inf_zero");
    ef = FLAGS_EN ? 4'b1000 : 4'b0000;
    checks++;
    if (fpFlags !== ef) begin failures++; $display("FAIL inf_zero_flags got=%b expected=%b", fpFlags, ef); end
    clear_flags();
    issue({32'hFFC00000, 32'h7FC00000}, {32'h3F800000, 32'h3F800000}, RNE, {32'h7FC00000, 32'h7FC00000});
    drain("qnan");
    checks++;
    if (fpFlags !== 4'd0) begin failures++; $display("FAIL qnan_flags got=%b expected=0000", fpFlags); end
    issue({32'h3F800000, 32'h7F800001}, {32'h3F800000, 32'h3F800000}, RNE, {32'h3F800000, 32'h7FC00000});
    drain("snan");
    checks++;
    if (fpFlags !== ef) begin failures++; $display("FAIL snan_flags got=%b expected=%b", fpFlags, ef); end
    issue({32'h3F800000, 32'h7F800000}, {32'h3F800000, 32'h00000000}, RNE, {32'h3F800000, 32'h7FC00000});
    tick();
    flagClr = 1'b1;
    tick();
    flagClr = 1'b0;
    checks += 2;
    if (outValid !== 1'b1) begin failures++; $display("FAIL clr_beat_valid got=%b expected=1", outValid); end
    if (fpFlags !== 4'd0) begin failures++; $display("FAIL clr_priority got=%b expected=0000", fpFlags); end
    drain("clr");
  endtask

  task automatic test_back_to_back;
    clear_flags();
    issue({32'h3F800000, 32'h3F800000}, {32'h3F000000, 32'h40000000}, RNE, {32'h3F000000, 32'h40000000});
    issue({32'h40000000, 32'h3FC00000}, {32'h3F000000, 32'h40000000}, RNE, {32'h3F800000, 32'h40400000});
    issue({32'h40800000, 32'h3FC00000}, {32'h3F000000, 32'h40400000}, RNE, {32'h40000000, 32'h40900000});
    exHold = 1'b1;
    regValRs = {32'h41200000, 32'h41200000};
    regValRt = {32'h41200000, 32'h41200000};
    inValid = 1'b1;
    for (int n = 0; n < 2; n++) begin
      tick();
      checks += 2;
      if (regValRo !== {32'h3F000000, 32'h40000000}) begin
        failures++;
        $display("FAIL hold_frozen_result cycle=%0d got=%h expected=3f00000040000000", n, regValRo);
      end
      if (outValid !== 1'b1) begin
        failures++;
        $display("FAIL hold_valid cycle=%0d got=%b expected=1", n, outValid);
      end
    end
    exHold = 1'b0;
    issue({32'h41000000, 32'h40000000}, {32'h3F000000, 32'h40000000}, RNE, {32'h40800000, 32'h40800000});
    drain("back_to_back");
  endtask

  task automatic test_reset_inflight;
    int seen = 0;
    issue({32'h3F800000, 32'h3F800000}, {32'h40000000, 32'h40000000}, RNE, {32'h40000000, 32'h40000000});
    issue({32'h3F800000, 32'h3F800000}, {32'h40400000, 32'h40400000}, RNE, {32'h40400000, 32'h40400000});
    issue({32'h3F800000, 32'h3F800000}, {32'h40800000, 32'h40800000}, RNE, {32'h40800000, 32'h40800000});
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (outValid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b expected=0", outValid); end
    if (regValRo !== 64'd0) begin failures++; $display("FAIL async_reset_result got=%h expected=0", regValRo); end
    sb.delete();
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      if (outValid) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL stale_beat count=%0d expected=0", seen); end
    issue({32'h40000000, 32'h3F800000}, {32'h40000000, 32'h3F800000}, RNE, {32'h40800000, 32'h3F800000});
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_mul_vec_sf.md
Name: fpu_mul_vec_sf

Overview:
- Parametrised, pipelined packed binary32 multiplier: LANES independent FP32 multiplies per issue.
- Full 24x24 significand product with selectable IEEE rounding, Inf/NaN/overflow handling and a valid-tagged 3-stage pipeline.
- Sits in the FPU execute path beside the scalar FP units; serves both scalar ops (LANES=1) and packed SIMD multiply ops.

Parameters:
- LANES, 2, number of 32-bit lanes; data buses are 32*LANES bits.
- DAZ, 1, 1 = denormal inputs and results flush to signed zero; 0 is reserved, and elaboration fails if DAZ=0.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- exHold  in  1  pipeline stall; when 1, all stage registers hold.
- inValid  in  1  operands valid this cycle.
- regValRs  in  32*LANES  packed operand A; lane i is bits [32i+31:32i].
- regValRt  in  32*LANES  packed operand B.
- regRMode  in  8  bits [1:0] rounding mode (0 RNE, 1 RTZ, 2 RDN, 3 RUP); bits [7:2] ignored.
- regValRo  out  32*LANES  packed result.
- outValid  out  1  regValRo holds a completed result.
- flagClr  in  1  clears the sticky flags.
- fpFlags  out  4  sticky flags {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset: all stage valid bits, regValRo, outValid and fpFlags go to 0 immediately (asynchronous).
- Latency: exactly 3 advancing cycles.
  - S1 registers unpacked sign, 10-bit biased exponent sum and special-case class.
  - S2 registers the 48-bit product plus the rounding mode.
  - S3 normalises by 0 or 1, rounds, and registers regValRo and outValid.
- Issue: a beat is accepted when inValid=1 and exHold=0.
- Throughput: one beat per cycle, no bubbles.
- Stall: while exHold=1, no stage advances, outputs hold, and inValid is ignored.
- outValid: pulses for one cycle per beat, except it stays high across a hold.
- Rounding mode: sampled with the operands at issue and carried down the pipe.
- Per lane, with Es and Et as the biased exponents: E = Es + Et - 127, computed at 10-bit signed width.
- Normalisation: product bit 47 set means shift right by 1 and E+1.
- Rounding: on the 24-bit significand using guard and sticky bits.
  - Round-up carry out of the significand means E+1 and significand = 1.0.
- Specials, in priority order:
  - Any NaN input, or Inf x 0: result 0x7FC00000 (sign bit 0), sets invalid; a quiet NaN propagating from an input does not set invalid, a signalling NaN does.
  - Inf x finite nonzero: signed Inf.
  - Zero or denormal input: signed zero, exact.
- Overflow (E >= 255 after rounding):
  - RNE, or the directed mode toward the result's sign: signed Inf.
  - Otherwise: signed max-finite 0x7F7FFFFF.
  - Sets overflow and inexact.
- Underflow (E <= 0 after normalisation): signed zero; sets underflow and inexact.
- Inexact: set when guard or sticky is nonzero.
- Flags: OR across all lanes; updated only when an S3 beat completes.
- flagClr: takes priority over a same-cycle update, and the same-cycle update is lost.
- Lanes are fully independent; there are no cross-lane carries.

Optional Feature:
- FPU_MULVEC_FLAGS_EN
- Defined: sticky flag logic exists as described above.
- Undefined: fpFlags is tied to 0, flagClr is ignored, and no flag registers are synthesised; result values are identical either way.

Decomposition:
- Shared package holds:
  - rounding-mode encodings;
  - FP32 field widths and constants (bias 127, QNAN 0x7FC00000, MAXF 0x7F7FFFFF, INF 0x7F800000);
  - special-class encoding (ZERO, NORM, INF, QNAN, SNAN).
- One natural sub-module: fpu_mul_sf_lane, a single-lane 3-stage datapath taking the shared valid/hold enables and emitting a 4-bit flag vector. The top instantiates it LANES times and owns the valid chain and sticky flags.

Test Plan:
- Lane0 0x3FC00000 x 0x40000000, lane1 0xC0400000 x 0x3F000000, RNE -> 3 cycles later 0x40400000 / 0xBFC00000, outValid for 1 cycle, flags 0.
- 0x3F800001 x 0x3F800001 -> RNE 0x3F800002, RTZ 0x3F800002, RUP 0x3F800003, inexact set; 0xBF800001 x 0x3F800001 with RDN -> 0xBF800003.
- 0x7F000000 x 0x7F000000 -> RNE 0x7F800000, RTZ 0x7F7FFFFF, overflow+inexact; 0x00800000 x 0x3F000000 -> 0x00000000, underflow+inexact.
- 0x7F800000 x 0x00000000 -> 0x7FC00000 + invalid; 0x7FC00000 x 0x3F800000 -> 0x7FC00000, invalid clear; assert flagClr on a completing beat -> fpFlags = 0.
- Back-to-back issue of 4 beats with exHold high for 2 cycles mid-stream -> results in order, no loss or duplication, outputs frozen during hold.
- Assert reset low with 2 beats in flight -> outValid and regValRo immediately 0; no stale beat appears after release.
